// File: rtl/quiz_pkg.sv
// Shared quiz definitions: FSM state encoding and default build constants.
// Used by the RNG, judge and display blocks.
package quiz_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_e;

    localparam int unsigned QUIZ_WIDTH       = 8;
    localparam int unsigned QUIZ_TICK_DIV    = 50_000_000;
    localparam int unsigned QUIZ_LIMIT_TICKS = 10;

endpackage

// File: rtl/tick_divider.sv
// Countdown tick generator: counts enabled cycles modulo TICK_DIV and flags
// the last cycle of each period.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart the period (accepted start)
//   en         : count this cycle (judge in RUN)
//   tick       : high in the enabled cycle where the count is TICK_DIV-1
module tick_divider #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_tick_cnt;
    logic          w_last;

    assign w_last = (r_tick_cnt == CNT_MAX);
    // Same-cycle strobe so the judge sees the tick in the cycle it happens.
    assign tick   = en && w_last;

    // Period counter, wraps at TICK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (clear) begin
            r_tick_cnt <= '0;
        end else if (en) begin
            r_tick_cnt <= w_last ? '0 : r_tick_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/quiz_judge.sv
// Quiz answer judge: latches a question on start, counts down, compares the
// submitted answer and reports pass/fail with running score counters.
//   start/question : begin a question, question sampled when accepted
//   submit/answer  : commit an answer during RUN
//   busy           : RUN or REPORT
//   time_left      : remaining countdown ticks
//   result/timeout : last verdict (levels, cleared on next accepted start)
//   result_valid   : one-cycle strobe in REPORT
//   pass_count     : total passes, saturating
//   streak         : consecutive passes, saturating
module quiz_judge
    import quiz_pkg::*;
#(
    parameter int unsigned WIDTH       = QUIZ_WIDTH,
    parameter int unsigned TICK_DIV    = QUIZ_TICK_DIV,
    parameter int unsigned LIMIT_TICKS = QUIZ_LIMIT_TICKS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] question,
    input  logic [WIDTH-1:0] answer,
    input  logic             submit,
    output logic             busy,
    output logic [7:0]       time_left,
    output logic             result,
    output logic             result_valid,
    output logic             timeout,
    output logic [7:0]       pass_count,
    output logic [7:0]       streak
);

    localparam logic [7:0] LIMIT = 8'(LIMIT_TICKS);
    localparam logic [7:0] SAT   = 8'hFF;

    state_e           r_state,        w_state_nxt;
    logic [WIDTH-1:0] r_q,            w_q_nxt;
    logic [7:0]       r_time_left,    w_time_left_nxt;
    logic             r_result,       w_result_nxt;
    logic             r_timeout,      w_timeout_nxt;
    logic             r_result_valid, w_result_valid_nxt;
    logic             r_busy,         w_busy_nxt;
    logic [7:0]       r_pass_count,   w_pass_count_nxt;
    logic [7:0]       r_streak,       w_streak_nxt;
    logic             w_start_acc;
    logic             w_tick;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_start_acc),
        .en    (r_state == RUN),
        .tick  (w_tick)
    );

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt        = r_state;
        w_q_nxt            = r_q;
        w_time_left_nxt    = r_time_left;
        w_result_nxt       = r_result;
        w_timeout_nxt      = r_timeout;
        w_result_valid_nxt = 1'b0;
        w_pass_count_nxt   = r_pass_count;
        w_streak_nxt       = r_streak;
        w_start_acc        = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_start_acc     = 1'b1;
                    w_q_nxt         = question;
                    w_time_left_nxt = LIMIT;
                    w_result_nxt    = 1'b0;
                    w_timeout_nxt   = 1'b0;
                    w_state_nxt     = RUN;
                end
            end
            RUN: begin
                // Submit beats a coincident final tick: no decrement, no timeout.
                if (submit) begin
                    w_result_nxt       = (answer == r_q);
                    w_timeout_nxt      = 1'b0;
                    w_result_valid_nxt = 1'b1;
                    w_state_nxt        = REPORT;
                end else if (w_tick) begin
                    w_time_left_nxt = r_time_left - 8'd1;
                    if (r_time_left == 8'd1) begin
                        w_result_nxt       = 1'b0;
                        w_timeout_nxt      = 1'b1;
                        w_result_valid_nxt = 1'b1;
                        w_state_nxt        = REPORT;
                    end
                end
            end
            REPORT: begin
                if (r_result) begin
                    w_pass_count_nxt = (r_pass_count == SAT) ? SAT : r_pass_count + 8'd1;
                    w_streak_nxt     = (r_streak == SAT) ? SAT : r_streak + 8'd1;
                end else begin
                    w_streak_nxt = 8'd0;
                end
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_q            <= '0;
            r_time_left    <= '0;
            r_result       <= 1'b0;
            r_timeout      <= 1'b0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_pass_count   <= '0;
            r_streak       <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_q            <= w_q_nxt;
            r_time_left    <= w_time_left_nxt;
            r_result       <= w_result_nxt;
            r_timeout      <= w_timeout_nxt;
            r_result_valid <= w_result_valid_nxt;
            r_busy         <= w_busy_nxt;
            r_pass_count   <= w_pass_count_nxt;
            r_streak       <= w_streak_nxt;
        end
    end

    assign busy         = r_busy;
    assign time_left    = r_time_left;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign timeout      = r_timeout;
    assign pass_count   = r_pass_count;
    assign streak       = r_streak;

endmodule

// File: tb/tb_quiz_judge.sv
// Self-checking bench for quiz_judge with a small scenario-level reference model.
module tb_quiz_judge;

    localparam int DIV     = 4;
    localparam int LIMIT   = 3;
    localparam int RUN_MAX = DIV * LIMIT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] question;
    logic [7:0] answer;
    logic       submit;
    logic       busy;
    logic [7:0] time_left;
    logic       result;
    logic       result_valid;
    logic       timeout;
    logic [7:0] pass_count;
    logic [7:0] streak;

    int errors = 0;
    int checks = 0;
    int m_pass = 0;
    int m_streak = 0;

    quiz_judge #(
        .WIDTH       (8),
        .TICK_DIV    (DIV),
        .LIMIT_TICKS (LIMIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .question     (question),
        .answer       (answer),
        .submit       (submit),
        .busy         (busy),
        .time_left    (time_left),
        .result       (result),
        .result_valid (result_valid),
        .timeout      (timeout),
        .pass_count   (pass_count),
        .streak       (streak)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full question: start, run ks cycles (ks outside 1..RUN_MAX = let it expire),
    // check countdown, verdict, counters and the idle state that follows.
    task automatic run_question(input logic [7:0] q, input logic [7:0] a, input int ks, input int gap);
        bit   by_submit;
        logic exp_res;
        logic [7:0] exp_tl;
        by_submit = (ks >= 1) && (ks <= RUN_MAX);
        question = q;
        start = 1'b1;
        step();
        start = 1'b0;
        question = 8'($urandom);
        for (int k = 1; k <= RUN_MAX; k++) begin
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL run_busy k=%0d: got %0b expected 1", k, busy); end
            checks++;
            if (time_left !== 8'(LIMIT - (k - 1) / DIV)) begin
                errors++; $display("FAIL run_time_left k=%0d: got %0d expected %0d", k, time_left, LIMIT - (k - 1) / DIV);
            end
            answer = (k == ks) ? a : 8'($urandom);
            submit = (k == ks);
            start = 1'($urandom_range(0, 1));
            step();
            submit = 1'b0;
            start = 1'b0;
            if (k == ks) break;
        end
        exp_res = by_submit ? (a == q) : 1'b0;
        exp_tl  = by_submit ? 8'(LIMIT - (ks - 1) / DIV) : 8'd0;
        checks++;
        if (result_valid !== 1'b1) begin errors++; $display("FAIL report_valid: got %0b expected 1", result_valid); end
        checks++;
        if (result !== exp_res) begin errors++; $display("FAIL report_result: got %0b expected %0b", result, exp_res); end
        checks++;
        if (timeout !== !by_submit) begin errors++; $display("FAIL report_timeout: got %0b expected %0b", timeout, !by_submit); end
        checks++;
        if (time_left !== exp_tl) begin errors++; $display("FAIL report_time_left: got %0d expected %0d", time_left, exp_tl); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL report_busy: got %0b expected 1", busy); end
        if (exp_res) begin
            m_pass   = (m_pass < 255) ? m_pass + 1 : 255;
            m_streak = (m_streak < 255) ? m_streak + 1 : 255;
        end else begin
            m_streak = 0;
        end
        start  = 1'($urandom_range(0, 1));
        submit = 1'($urandom_range(0, 1));
        step();
        start  = 1'b0;
        submit = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++; $display("FAIL idle_after_report: got busy=%0b valid=%0b expected 0 0", busy, result_valid);
        end
        checks++;
        if (pass_count !== 8'(m_pass)) begin errors++; $display("FAIL pass_count: got %0d expected %0d", pass_count, m_pass); end
        checks++;
        if (streak !== 8'(m_streak)) begin errors++; $display("FAIL streak: got %0d expected %0d", streak, m_streak); end
        checks++;
        if (result !== exp_res || timeout !== !by_submit) begin
            errors++; $display("FAIL held_verdict: got result=%0b timeout=%0b expected %0b %0b", result, timeout, exp_res, !by_submit);
        end
        for (int g = 0; g < gap; g++) begin
            submit = 1'($urandom_range(0, 1));
            step();
            submit = 1'b0;
            checks++;
            if (busy !== 1'b0 || result_valid !== 1'b0 || result !== exp_res) begin
                errors++; $display("FAIL idle_gap: got busy=%0b valid=%0b result=%0b expected 0 0 %0b", busy, result_valid, result, exp_res);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; submit = 1'b0; question = '0; answer = '0;
        step(); step();
        checks++;
        if ({busy, time_left, result, result_valid, timeout, pass_count, streak} !== '0) begin
            errors++; $display("FAIL reset_outputs: got busy=%0b tl=%0d res=%0b v=%0b to=%0b pc=%0d st=%0d expected all 0",
                               busy, time_left, result, result_valid, timeout, pass_count, streak);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            submit = 1'b1; answer = 8'($urandom);
            step();
            submit = 1'b0;
            checks++;
            if (result_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL idle_submit_ignored: got valid=%0b busy=%0b expected 0 0", result_valid, busy);
            end
        end
    endtask

    task automatic test_correct();
        run_question(8'hA5, 8'hA5, 2, 1);
    endtask

    task automatic test_wrong();
        run_question(8'h3C, 8'hC3, 5, 0);
    endtask

    task automatic test_timeout();
        run_question(8'h5A, 8'h5A, 0, 1);
    endtask

    task automatic test_collision();
        run_question(8'h77, 8'h77, RUN_MAX, 0);
    endtask

    task automatic test_random();
        logic [7:0] q;
        logic [7:0] a;
        for (int i = 0; i < 40; i++) begin
            q = 8'($urandom);
            a = ($urandom_range(0, 2) != 0) ? q : 8'($urandom);
            run_question(q, a, int'($urandom_range(1, RUN_MAX + 2)), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_reset_mid_run();
        question = 8'h11; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, time_left, result, result_valid, timeout, pass_count, streak} !== '0) begin
            errors++; $display("FAIL mid_run_reset: got busy=%0b tl=%0d res=%0b pc=%0d st=%0d expected all 0",
                               busy, time_left, result, pass_count, streak);
        end
        m_pass = 0; m_streak = 0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got busy=%0b expected 0", busy); end
    endtask

    task automatic test_saturation();
        logic [7:0] q;
        for (int i = 0; i < 257; i++) begin
            q = 8'($urandom);
            run_question(q, q, 1, 0);
        end
        checks++;
        if (pass_count !== 8'd255 || streak !== 8'd255) begin
            errors++; $display("FAIL saturation: got pc=%0d st=%0d expected 255 255", pass_count, streak);
        end
        run_question(8'h01, 8'h02, 3, 0);
        checks++;
        if (pass_count !== 8'd255 || streak !== 8'd0) begin
            errors++; $display("FAIL after_sat_fail: got pc=%0d st=%0d expected 255 0", pass_count, streak);
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_wrong();
        test_timeout();
        test_collision();
        test_random();
        test_reset_mid_run();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
